// File: rtl/gpu_bus_master_pkg.sv
// gpu_bus_master_pkg: shared GPU bus-master types and constants
package gpu_bus_master_pkg;
   typedef enum logic {OP_READ, OP_FILL} bus_op_t;
   typedef enum logic [2:0] {IDLE, READ, FILL, DRAIN, DONE} master_state_t;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/gpu_sync_fifo.sv
// gpu_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module gpu_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic                   valid,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   always_comb begin
      valid = count != '0;
      head = mem[rd_ptr];
      do_pop = pop & valid;
      do_push = push & ((32'(count) < 32'(DEPTH)) | do_pop);
   end
   always_ff @(posedge clock)
      if (do_push) mem[wr_ptr] <= push_data;
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_ptr <= (32'(wr_ptr) == 32'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= (32'(rd_ptr) == 32'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/gpu_bus_master.sv
// gpu_bus_master: Avalon-MM initiator executing READ (into a FWFT FIFO) and FILL commands
module gpu_bus_master
   import gpu_bus_master_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_STRIDE = WORD_BYTES
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_count,
   input  logic [31:0] cmd_data,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        done,
   output logic [31:0] m1_address,
   output logic        m1_read,
   output logic        m1_write,
   output logic [31:0] m1_writedata,
   input  logic        m1_waitrequest,
   input  logic [31:0] m1_readdata,
   input  logic        m1_readdatavalid
);
   localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   master_state_t state;
   logic [31:0] count, issued, issued_next;
   logic [OW-1:0] outstanding, outstanding_next;
   logic [CW-1:0] fifo_count, fifo_count_next;
   logic accept, rd_accept, resp, pop, credit, last;
   always_comb begin
      cmd_ready = state == IDLE;
      busy = state != IDLE;
      done = state == DONE;
      accept = (m1_read | m1_write) & ~m1_waitrequest;
      rd_accept = m1_read & ~m1_waitrequest;
      resp = m1_readdatavalid & (outstanding != '0);
      pop = rd_valid & rd_ready;
      outstanding_next = outstanding + OW'(rd_accept) - OW'(resp);
      fifo_count_next = fifo_count + CW'(resp) - CW'(pop);
      issued_next = issued + 32'(accept);
      last = accept & (issued_next == count);
      // every issued read must have a FIFO slot reserved before its response can arrive
      credit = (32'(outstanding_next) + 32'(fifo_count_next) < 32'(FIFO_DEPTH))
             & (32'(outstanding_next) < 32'(MAX_OUTSTANDING));
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
         issued <= '0;
         outstanding <= '0;
         m1_address <= '0;
         m1_read <= 1'b0;
         m1_write <= 1'b0;
         m1_writedata <= '0;
      end else begin
         outstanding <= outstanding_next;
         case (state)
            IDLE:
               if (cmd_valid) begin
                  count <= cmd_count;
                  issued <= '0;
                  m1_address <= cmd_addr;
                  m1_writedata <= cmd_data;
                  if (cmd_count == '0) state <= DONE;
                  else if (cmd_op == OP_FILL) begin
                     state <= FILL;
                     m1_write <= 1'b1;
                  end else begin
                     state <= READ;
                     m1_read <= credit;
                  end
               end
            READ: begin
               issued <= issued_next;
               if (rd_accept) m1_address <= m1_address + 32'(ADDR_STRIDE);
               if (last) state <= DRAIN;
               m1_read <= last ? 1'b0 : (m1_read & m1_waitrequest) | credit;
            end
            FILL: begin
               issued <= issued_next;
               if (accept) m1_address <= m1_address + 32'(ADDR_STRIDE);
               if (last) begin
                  state <= DONE;
                  m1_write <= 1'b0;
               end
            end
            DRAIN: if (outstanding_next == '0) state <= DONE;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   gpu_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock(clock),
      .reset(reset),
      .push(resp),
      .push_data(m1_readdata),
      .pop(pop),
      .head(rd_data),
      .valid(rd_valid),
      .count(fifo_count)
   );
endmodule

// File: tb/tb_gpu_bus_master.sv
// tb_gpu_bus_master: directed self-checking bench with a latency-configurable memory responder
module tb_gpu_bus_master;
   import gpu_bus_master_pkg::*;
   logic clock = 1'b0, reset;
   logic cmd_valid, cmd_ready, cmd_op;
   logic [31:0] cmd_addr, cmd_count, cmd_data, rd_data;
   logic rd_valid, rd_ready, busy, done;
   logic [31:0] m1_address, m1_writedata, m1_readdata;
   logic m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
   int tests = 0, fails = 0;
   int cyc = 0, delivered = 0, rd_lat = 2;
   logic [31:0] pend_a [$];
   int pend_t [$];

   always #5 clock = ~clock;

   gpu_bus_master dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_count(cmd_count), .cmd_data(cmd_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid)
   );

   // memory returns addr ^ 0xFFFF, rd_lat cycles after the read is seen
   initial begin : mem_model
      m1_readdatavalid = 1'b0;
      m1_readdata = '0;
      forever begin
         @(negedge clock);
         cyc++;
         m1_readdatavalid = 1'b0;
         if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
            m1_readdatavalid = 1'b1;
            m1_readdata = pend_a.pop_front() ^ 32'h0000_FFFF;
            void'(pend_t.pop_front());
            delivered++;
         end
         if (m1_read && !m1_waitrequest && !reset) begin
            pend_a.push_back(m1_address);
            pend_t.push_back(cyc + rd_lat);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic send(input logic op, input logic [31:0] a, input logic [31:0] n, input logic [31:0] d);
      int w = 0;
      while (!cmd_ready && w < 100) begin
         @(negedge clock);
         w++;
      end
      if (!cmd_ready) begin
         tests++; fails++;
         $display("FAIL send_wait cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_count = n; cmd_data = d;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      tests++;
      if ({cmd_ready, busy, done, rd_valid, m1_read, m1_write} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_flags got rdy=%b busy=%b done=%b rv=%b rd=%b wr=%b required 1 0 0 0 0 0",
                  cmd_ready, busy, done, rd_valid, m1_read, m1_write);
      end
      tests++;
      if (m1_address !== 32'h0) begin
         fails++; $display("FAIL reset_addr got %h required 00000000", m1_address);
      end
      tests++;
      if (m1_writedata !== 32'h0) begin
         fails++; $display("FAIL reset_wdata got %h required 00000000", m1_writedata);
      end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_fill_basic();
      logic [31:0] exp_a [3] = '{32'h0800_0000, 32'h0800_0004, 32'h0800_0008};
      send(OP_FILL, 32'h0800_0000, 32'd3, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         tests++;
         if ({m1_write, m1_read, m1_address, m1_writedata} !== {2'b10, exp_a[i], 32'h1234_5678}) begin
            fails++;
            $display("FAIL fill_beat%0d got wr=%b rd=%b a=%h d=%h required 1 0 %h 12345678",
                     i, m1_write, m1_read, m1_address, m1_writedata, exp_a[i]);
         end
         @(negedge clock);
      end
      tests++;
      if ({done, m1_write, cmd_ready} !== 3'b100) begin
         fails++; $display("FAIL fill_done got done=%b wr=%b rdy=%b required 1 0 0", done, m1_write, cmd_ready);
      end
      @(negedge clock);
      tests++;
      if ({done, cmd_ready} !== 2'b01) begin
         fails++; $display("FAIL fill_idle got done=%b rdy=%b required 0 1", done, cmd_ready);
      end
   endtask

   task automatic test_fill_wait();
      int writes = 0;
      m1_waitrequest = 1'b1;
      send(OP_FILL, 32'h0000_0200, 32'd2, 32'hCAFE_F00D);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ({m1_write, m1_address, m1_writedata} !== {1'b1, 32'h0000_0200, 32'hCAFE_F00D}) begin
            fails++;
            $display("FAIL fillw_hold%0d got wr=%b a=%h d=%h required 1 00000200 cafef00d",
                     i, m1_write, m1_address, m1_writedata);
         end
         if (i == 3) m1_waitrequest = 1'b0;
         if (m1_write && !m1_waitrequest) writes++;
         @(negedge clock);
      end
      tests++;
      if ({m1_write, m1_address} !== {1'b1, 32'h0000_0204}) begin
         fails++; $display("FAIL fillw_second got wr=%b a=%h required 1 00000204", m1_write, m1_address);
      end
      if (m1_write && !m1_waitrequest) writes++;
      @(negedge clock);
      tests++;
      if ({done, m1_write} !== 2'b10) begin
         fails++; $display("FAIL fillw_done got done=%b wr=%b required 1 0", done, m1_write);
      end
      tests++;
      if (writes !== 2) begin
         fails++; $display("FAIL fillw_count got %0d writes required 2", writes);
      end
      @(negedge clock);
   endtask

   task automatic test_read_basic();
      logic [31:0] exp_d [4] = '{32'h0000_FEFF, 32'h0000_FEFB, 32'h0000_FEF7, 32'h0000_FEF3};
      logic [31:0] got [$];
      int at_done = -1;
      rd_ready = 1'b1;
      send(OP_READ, 32'h0000_0100, 32'd4, 32'h0);
      for (int c = 0; c < 40 && at_done < 0; c++) begin
         if (rd_valid && rd_ready) got.push_back(rd_data);
         if (done) at_done = got.size();
         @(negedge clock);
      end
      tests++;
      if (at_done !== 4) begin
         fails++; $display("FAIL read_done_timing got %0d words at done required 4", at_done);
      end
      tests++;
      if (got.size() !== 4) begin
         fails++; $display("FAIL read_count got %0d words required 4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_d[i]) begin
            fails++; $display("FAIL read_word%0d got %h required %h", i, got[i], exp_d[i]);
         end
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_read_backpressure();
      logic [31:0] got [$];
      int issued = 0, pops = 0;
      logic done_seen = 1'b0;
      rd_ready = 1'b0;
      send(OP_READ, 32'h0000_1000, 32'd12, 32'h0);
      for (int c = 0; c < 30; c++) begin
         if (m1_read && !m1_waitrequest) issued++;
         if (rd_valid && rd_ready) pops++;
         @(negedge clock);
      end
      tests++;
      if (issued !== 8) begin
         fails++; $display("FAIL bp_stall_issued got %0d required 8", issued);
      end
      tests++;
      if ({rd_valid, rd_data, busy, m1_read} !== {1'b1, 32'h0000_EFFF, 2'b10}) begin
         fails++;
         $display("FAIL bp_stall_state got rv=%b head=%h busy=%b rd=%b required 1 0000efff 1 0",
                  rd_valid, rd_data, busy, m1_read);
      end
      rd_ready = 1'b1;
      for (int c = 0; c < 200 && !(done_seen && got.size() == 12); c++) begin
         if (m1_read && !m1_waitrequest) issued++;
         if (rd_valid && rd_ready) got.push_back(rd_data);
         if (done) done_seen = 1'b1;
         @(negedge clock);
      end
      tests++;
      if ({done_seen, 32'(issued)} !== {1'b1, 32'd12}) begin
         fails++; $display("FAIL bp_total got done=%b issued=%0d required 1 12", done_seen, issued);
      end
      tests++;
      if (got.size() !== 12) begin
         fails++; $display("FAIL bp_count got %0d words required 12", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         tests++;
         if (got[i] !== ((32'h0000_1000 + 32'(4 * i)) ^ 32'h0000_FFFF)) begin
            fails++;
            $display("FAIL bp_word%0d got %h required %h", i, got[i], (32'h0000_1000 + 32'(4 * i)) ^ 32'h0000_FFFF);
         end
      end
      rd_ready = 1'b0;
   endtask

   task automatic test_zero_count();
      for (int k = 0; k < 2; k++) begin
         send(k == 0 ? OP_FILL : OP_READ, 32'h0000_0400, 32'd0, 32'h0000_DEAD);
         tests++;
         if ({done, m1_read, m1_write} !== 3'b100) begin
            fails++; $display("FAIL zero%0d_done got done=%b rd=%b wr=%b required 1 0 0", k, done, m1_read, m1_write);
         end
         @(negedge clock);
         tests++;
         if ({done, cmd_ready, m1_read, m1_write} !== 4'b0100) begin
            fails++;
            $display("FAIL zero%0d_idle got done=%b rdy=%b rd=%b wr=%b required 0 1 0 0",
                     k, done, cmd_ready, m1_read, m1_write);
         end
      end
   endtask

   task automatic test_reset_mid();
      int d0, bad = 0;
      rd_lat = 20;
      rd_ready = 1'b1;
      send(OP_READ, 32'h0000_0300, 32'd3, 32'h0);
      repeat (3) @(negedge clock);
      tests++;
      if (pend_a.size() !== 3) begin
         fails++; $display("FAIL rst_pending got %0d outstanding required 3", pend_a.size());
      end
      d0 = delivered;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (rd_valid || m1_read || m1_write) bad++;
         @(negedge clock);
      end
      tests++;
      if (delivered - d0 !== 3) begin
         fails++; $display("FAIL rst_strays got %0d stray responses required 3", delivered - d0);
      end
      tests++;
      if (bad !== 0) begin
         fails++; $display("FAIL rst_quiet got %0d active cycles required 0", bad);
      end
      tests++;
      if ({rd_valid, cmd_ready, busy} !== 3'b010 || dut.outstanding !== '0 || dut.state !== IDLE) begin
         fails++;
         $display("FAIL rst_final got rv=%b rdy=%b busy=%b outst=%0d state=%0d required 0 1 0 0 %0d",
                  rd_valid, cmd_ready, busy, dut.outstanding, dut.state, IDLE);
      end
      rd_lat = 2;
      rd_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_count = '0; cmd_data = '0;
      rd_ready = 1'b0; m1_waitrequest = 1'b0;
      repeat (3) @(negedge clock);
      test_reset();
      test_fill_basic();
      test_fill_wait();
      test_read_basic();
      test_read_backpressure();
      test_zero_count();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
